// File: rtl/gqa_pkg.sv
// Shared definitions for the grouped-query-attention scatter/gather stages.
// Provides the derived-size helpers (head size, packet depths, counter widths)
// and a packed counter-state type describing where a stream walk stands.
// Optional feature in users of this package: GQA_GATHER_OUT_REG_EN.

package gqa_pkg;

    // Columns owned by one head along dim 0.
    function automatic int gqa_head_size(input int dim_0, input int num_heads);
        return dim_0 / num_heads;
    endfunction

    // Packets needed to cover `size` elements at `par` elements per packet.
    function automatic int gqa_depth(input int size, input int par);
        return size / par;
    endfunction

    // Counter width for a counter running 0..depth-1, never narrower than 1 bit.
    function automatic int gqa_ctr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Per-counter "sitting at its last value" flags for the block/head/row walk.
    typedef struct packed {
        logic row_max;
        logic head_max;
        logic blk_max;
    } gqa_ctr_state_t;

    // The final packet of a tensor is the one where every counter is at its end.
    function automatic logic gqa_is_last(input gqa_ctr_state_t st);
        return st.row_max & st.head_max & st.blk_max;
    endfunction

endpackage : gqa_pkg

// File: rtl/gqa_gather_skid_buffer.sv
// Two-entry skid buffer used on the gathered output stream when
// GQA_GATHER_OUT_REG_EN is defined. The upstream ready is a flop, so there is
// no combinational path from out_ready_i back to in_ready_o. One main entry
// drives the output; the skid entry catches the packet accepted in the cycle
// the output stalls. Steady-state latency is one cycle at full throughput.

module gqa_gather_skid_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  in_ready_q;
    logic                  in_fire;

    assign in_fire = in_valid_i & in_ready_q;

    // Next-state for the main and skid entries.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_ready_i) begin
            // Output slot frees this cycle: refill from skid first to keep order.
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_data_d  = in_data_i;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output held: park the packet accepted on the registered ready.
            skid_data_d  = in_data_i;
            skid_valid_d = 1'b1;
        end
    end

    // State registers; ready is registered from the skid occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so the output bus reads zero out of reset.
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule : gqa_gather_skid_buffer

// File: rtl/gqa_head_gather.sv
// Gathers NUM_HEADS per-head attention streams back into one row-major stream.
// Walk order per tensor: rows, then heads, then dim-0 blocks of one head, so
// head h's columns land at dim-0 offset h*HEAD_SIZE. Only the head selected by
// head_ctr is handshaken; the others see ready low and stall upstream.
// Build option GQA_GATHER_OUT_REG_EN: place a two-entry skid buffer between
// the mux and the outputs (1-cycle latency, registered ready). Without it the
// output is a purely combinational mux of the selected head.

module gqa_head_gather
    import gqa_pkg::*;
#(
    parameter int NUM_HEADS                 = 12,
    parameter int IN_DATA_TENSOR_SIZE_DIM_0 = 768,
    parameter int IN_DATA_TENSOR_SIZE_DIM_1 = 32,
    parameter int IN_DATA_PARALLELISM_DIM_0 = 4,
    parameter int IN_DATA_PARALLELISM_DIM_1 = 4,
    parameter int IN_DATA_PRECISION_0       = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [NUM_HEADS*IN_DATA_PARALLELISM_DIM_0*IN_DATA_PARALLELISM_DIM_1*IN_DATA_PRECISION_0-1:0] data_in,
    input  logic [NUM_HEADS-1:0]                                   data_in_valid,
    output logic [NUM_HEADS-1:0]                                   data_in_ready,
    output logic [IN_DATA_PARALLELISM_DIM_0*IN_DATA_PARALLELISM_DIM_1*IN_DATA_PRECISION_0-1:0] data_out,
    output logic                                                   data_out_valid,
    input  logic                                                   data_out_ready,
    output logic                                                   data_out_last
);

    localparam int P         = IN_DATA_PARALLELISM_DIM_0 * IN_DATA_PARALLELISM_DIM_1;
    localparam int PKT_W     = P * IN_DATA_PRECISION_0;
    localparam int HEAD_SIZE = gqa_head_size(IN_DATA_TENSOR_SIZE_DIM_0, NUM_HEADS);
    localparam int DEPTH_0   = gqa_depth(HEAD_SIZE, IN_DATA_PARALLELISM_DIM_0);
    localparam int DEPTH_1   = gqa_depth(IN_DATA_TENSOR_SIZE_DIM_1, IN_DATA_PARALLELISM_DIM_1);
    localparam int BLK_W     = gqa_ctr_width(DEPTH_0);
    localparam int HEAD_W    = gqa_ctr_width(NUM_HEADS);
    localparam int ROW_W     = gqa_ctr_width(DEPTH_1);

    localparam logic [BLK_W-1:0]  BLK_MAX  = BLK_W'(DEPTH_0 - 1);
    localparam logic [HEAD_W-1:0] HEAD_MAX = HEAD_W'(NUM_HEADS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(DEPTH_1 - 1);

    // Reject geometries that do not tile exactly into heads and packets.
    if (IN_DATA_TENSOR_SIZE_DIM_0 % NUM_HEADS != 0) begin : g_chk_heads
        $error("gqa_head_gather: DIM_0 must be a multiple of NUM_HEADS");
    end
    if (HEAD_SIZE % IN_DATA_PARALLELISM_DIM_0 != 0) begin : g_chk_par0
        $error("gqa_head_gather: head size must be a multiple of PARALLELISM_DIM_0");
    end
    if (IN_DATA_TENSOR_SIZE_DIM_1 % IN_DATA_PARALLELISM_DIM_1 != 0) begin : g_chk_par1
        $error("gqa_head_gather: DIM_1 must be a multiple of PARALLELISM_DIM_1");
    end

    logic [BLK_W-1:0]  blk_ctr_q,  blk_ctr_d;
    logic [HEAD_W-1:0] head_ctr_q, head_ctr_d;
    logic [ROW_W-1:0]  row_ctr_q,  row_ctr_d;

    logic [PKT_W-1:0]  in_pkts [NUM_HEADS];
    logic [PKT_W-1:0]  sel_data;
    logic              sel_valid;
    logic              sel_fire;
    logic              mux_ready;
    logic              last_flag;
    gqa_ctr_state_t    ctr_state;

    // Flat per-head bus viewed as one packet per head, head 0 in the low bits.
    for (genvar h = 0; h < NUM_HEADS; h++) begin : g_unpack
        assign in_pkts[h] = data_in[h*PKT_W +: PKT_W];
    end

    assign sel_valid = data_in_valid[head_ctr_q];
    assign sel_data  = in_pkts[head_ctr_q];
    assign sel_fire  = sel_valid & mux_ready;

    assign ctr_state = '{
        row_max:  (row_ctr_q  == ROW_MAX),
        head_max: (head_ctr_q == HEAD_MAX),
        blk_max:  (blk_ctr_q  == BLK_MAX)
    };
    assign last_flag = gqa_is_last(ctr_state);

    // Route the downstream ready to the selected head only.
    always_comb begin
        data_in_ready             = '0;
        data_in_ready[head_ctr_q] = mux_ready;
    end

    // Nested block/head/row walk; advances only on an accepted selected packet.
    always_comb begin
        blk_ctr_d  = blk_ctr_q;
        head_ctr_d = head_ctr_q;
        row_ctr_d  = row_ctr_q;
        if (sel_fire) begin
            if (ctr_state.blk_max) begin
                blk_ctr_d = '0;
                if (ctr_state.head_max) begin
                    head_ctr_d = '0;
                    // Row wrap starts the next tensor immediately, no idle cycle.
                    row_ctr_d = ctr_state.row_max ? '0 : row_ctr_q + ROW_W'(1);
                end else begin
                    head_ctr_d = head_ctr_q + HEAD_W'(1);
                end
            end else begin
                blk_ctr_d = blk_ctr_q + BLK_W'(1);
            end
        end
    end

    // Counter registers; reset discards any partial tensor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_ctr_q  <= '0;
            head_ctr_q <= '0;
            row_ctr_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so all counters see the same pre-edge state.
            blk_ctr_q  <= blk_ctr_d;
            head_ctr_q <= head_ctr_d;
            row_ctr_q  <= row_ctr_d;
        end
    end

`ifdef GQA_GATHER_OUT_REG_EN

    logic [PKT_W:0] skid_out;
    logic           skid_in_ready;

    // last travels with its packet through the buffer.
    gqa_gather_skid_buffer #(
        .DATA_WIDTH (PKT_W + 1)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst),
        .in_data_i   ({last_flag, sel_data}),
        .in_valid_i  (sel_valid),
        .in_ready_o  (skid_in_ready),
        .out_data_o  (skid_out),
        .out_valid_o (data_out_valid),
        .out_ready_i (data_out_ready)
    );

    assign mux_ready     = skid_in_ready;
    assign data_out      = skid_out[PKT_W-1:0];
    assign data_out_last = skid_out[PKT_W];

`else

    // Zero-latency path; everything is forced quiet while reset is held.
    assign mux_ready      = data_out_ready & rst;
    assign data_out_valid = sel_valid & rst;
    assign data_out       = rst ? sel_data : '0;
    assign data_out_last  = sel_valid & rst & last_flag;

`endif

endmodule : gqa_head_gather

// File: tb/tb_gqa_head_gather.sv
// Self-checking bench for gqa_head_gather (4 heads, 16x4 tensor, 2x2 packets).
// Each head owns a list of random packets; the expected output stream is
// built from the row/head/block ordering rule, and every handshake is scored.
// Honours GQA_GATHER_OUT_REG_EN (expects one cycle of latency when defined).

module tb_gqa_head_gather;

    localparam int NH         = 4;
    localparam int D0         = 16;
    localparam int D1         = 4;
    localparam int P0         = 2;
    localparam int P1         = 2;
    localparam int PREC       = 16;
    localparam int PKT_W      = P0 * P1 * PREC;
    localparam int DEP0       = (D0 / NH) / P0;
    localparam int DEP1       = D1 / P1;
    localparam int PER_HEAD   = DEP0 * DEP1;
    localparam int PER_TENSOR = PER_HEAD * NH;
    localparam int MAX_T      = 2;
    localparam int TIMEOUT    = 1000;

`ifdef GQA_GATHER_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic                   clk;
    logic                   rst;
    logic [NH*PKT_W-1:0]    data_in;
    logic [NH-1:0]          data_in_valid;
    logic [NH-1:0]          data_in_ready;
    logic [PKT_W-1:0]       data_out;
    logic                   data_out_valid;
    logic                   data_out_ready;
    logic                   data_out_last;

    gqa_head_gather #(
        .NUM_HEADS                 (NH),
        .IN_DATA_TENSOR_SIZE_DIM_0 (D0),
        .IN_DATA_TENSOR_SIZE_DIM_1 (D1),
        .IN_DATA_PARALLELISM_DIM_0 (P0),
        .IN_DATA_PARALLELISM_DIM_1 (P1),
        .IN_DATA_PRECISION_0       (PREC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out_last  (data_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PKT_W-1:0] d;
        bit               last;
    } exp_t;

    int               tests_run = 0;
    int               fails     = 0;

    logic [PKT_W-1:0] src [NH][PER_HEAD*MAX_T];
    int               idx [NH];
    bit               vld_hold [NH];
    exp_t             exp_q [$];
    int               head_order [PER_TENSOR];
    int               in_pos, out_cnt, cyc;
    int               first_in, first_out, last_out, fifth_cyc;
    int               lim;
    bit               prev_stall;
    logic [PKT_W-1:0] prev_data;

    // Build the per-head sources and the expected gathered stream.
    task automatic init_model(input int tensors);
        lim = tensors * PER_HEAD;
        for (int h = 0; h < NH; h++) begin
            for (int k = 0; k < lim; k++) begin
                src[h][k] = {$urandom(), $urandom()};
                src[h][k][15:0] = {8'(h), 8'(k)};
            end
            idx[h]      = 0;
            vld_hold[h] = 1'b0;
        end
        exp_q.delete();
        for (int t = 0; t < tensors; t++)
            for (int r = 0; r < DEP1; r++)
                for (int h = 0; h < NH; h++)
                    for (int b = 0; b < DEP0; b++)
                        exp_q.push_back('{src[h][t*PER_HEAD + r*DEP0 + b],
                                          (r == DEP1-1) && (h == NH-1) && (b == DEP0-1)});
        for (int p = 0; p < PER_TENSOR; p++)
            head_order[p] = (p / DEP0) % NH;
        in_pos = 0; out_cnt = 0; cyc = 0;
        first_in = -1; first_out = -1; last_out = -1; fifth_cyc = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
    endtask

    // Hold reset for one cycle with busy inputs and check the quiet outputs.
    task automatic apply_reset();
        @(negedge clk);
        rst            = 1'b0;
        data_in_valid  = '1;
        data_out_ready = 1'b1;
        for (int h = 0; h < NH; h++) data_in[h*PKT_W +: PKT_W] = {$urandom(), $urandom()};
        #1;
        tests_run++;
        if (data_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", data_out_valid); end
        tests_run++;
        if (data_out_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b want 0", data_out_last); end
        tests_run++;
        if (data_out !== '0) begin fails++; $display("FAIL rst_data: got %h want 0", data_out); end
        tests_run++;
        if (data_in_ready !== '0) begin fails++; $display("FAIL rst_ready: got %b want 0", data_in_ready); end
        @(negedge clk);
        data_in_valid  = '0;
        data_out_ready = 1'b0;
        rst            = 1'b1;
    endtask

    // One cycle: drive at negedge, then score every handshake seen this cycle.
    // mode 0: all valid, ready 1; 1: head 2 late by 10 cycles; 2: ready 1010..;
    // 3: random sticky valids and random ready.
    task automatic step(input int mode);
        int   exp_head;
        bit   en;
        exp_t e;
        @(negedge clk);
        for (int h = 0; h < NH; h++) begin
            case (mode)
                1:       en = (h != 2) || (cyc >= 10);
                3:       en = vld_hold[h] || ($urandom_range(0, 3) != 0);
                default: en = 1'b1;
            endcase
            if (idx[h] >= lim) en = 1'b0;
            vld_hold[h]      = en;
            data_in_valid[h] = en;
            data_in[h*PKT_W +: PKT_W] = (idx[h] < lim) ? src[h][idx[h]] : '0;
        end
        case (mode)
            2:       data_out_ready = (cyc % 2 == 0);
            3:       data_out_ready = ($urandom_range(0, 2) != 0);
            default: data_out_ready = 1'b1;
        endcase
        #1;
        exp_head = head_order[in_pos % PER_TENSOR];
        tests_run++;
        if ((data_in_ready & ~(NH'(1) << exp_head)) !== '0) begin
            fails++;
            $display("FAIL ready_mask: got %b, only head %0d may be ready (cycle %0d)", data_in_ready, exp_head, cyc);
        end
        for (int h = 0; h < NH; h++) begin
            if (data_in_valid[h] && data_in_ready[h]) begin
                tests_run++;
                if (h != exp_head) begin
                    fails++;
                    $display("FAIL in_order: got head %0d want head %0d", h, exp_head);
                end
                idx[h]++;
                vld_hold[h] = 1'b0;
                in_pos++;
                if (first_in < 0) first_in = cyc;
            end
        end
        if (prev_stall) begin
            tests_run++;
            if (data_out_valid !== 1'b1 || data_out !== prev_data) begin
                fails++;
                $display("FAIL stall_stable: got v=%b d=%h want v=1 d=%h", data_out_valid, data_out, prev_data);
            end
        end
        if (data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL extra_pkt: got %h want no packet", data_out);
            end else begin
                e = exp_q.pop_front();
                tests_run++;
                if (data_out !== e.d) begin
                    fails++;
                    $display("FAIL out_data: pkt %0d got %h want %h", out_cnt, data_out, e.d);
                end
                tests_run++;
                if (data_out_last !== e.last) begin
                    fails++;
                    $display("FAIL out_last: pkt %0d got %b want %b", out_cnt, data_out_last, e.last);
                end
            end
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (out_cnt == 5) fifth_cyc = cyc;
        end
        prev_stall = data_out_valid && !data_out_ready;
        prev_data  = data_out;
        cyc++;
    endtask

    task automatic run(input int mode, input int target);
        while (out_cnt < target && cyc < TIMEOUT) step(mode);
        if (out_cnt < target) begin
            tests_run++;
            fails++;
            $display("FAIL timeout: got %0d packets want %0d", out_cnt, target);
        end
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: got %0d pending want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_stream();
        apply_reset();
        init_model(1);
        run(0, PER_TENSOR);
        check_drained("stream");
        tests_run++;
        if (first_out - first_in != LAT) begin
            fails++;
            $display("FAIL stream_latency: got %0d want %0d", first_out - first_in, LAT);
        end
        tests_run++;
        if (last_out != PER_TENSOR - 1 + LAT) begin
            fails++;
            $display("FAIL stream_rate: last at cycle %0d want %0d", last_out, PER_TENSOR - 1 + LAT);
        end
    endtask

    task automatic test_head_delay();
        apply_reset();
        init_model(1);
        run(1, PER_TENSOR);
        check_drained("delay");
        tests_run++;
        if (fifth_cyc < 10) begin
            fails++;
            $display("FAIL delay_stall: 5th packet at cycle %0d want >= 10", fifth_cyc);
        end
    endtask

    task automatic test_ready_toggle();
        apply_reset();
        init_model(1);
        run(2, PER_TENSOR);
        check_drained("toggle");
        tests_run++;
        if (last_out > 2 * (PER_TENSOR - 1) + 2 * LAT) begin
            fails++;
            $display("FAIL toggle_rate: last at cycle %0d want <= %0d", last_out, 2 * (PER_TENSOR - 1) + 2 * LAT);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        init_model(2);
        run(0, 2 * PER_TENSOR);
        check_drained("b2b");
        tests_run++;
        if (last_out - first_out != 2 * PER_TENSOR - 1) begin
            fails++;
            $display("FAIL b2b_bubble: span %0d cycles want %0d", last_out - first_out, 2 * PER_TENSOR - 1);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        init_model(1);
        run(0, 5);
        apply_reset();
        init_model(1);
        run(0, PER_TENSOR);
        check_drained("reset_mid");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            init_model(2);
            run(3, 2 * PER_TENSOR);
            check_drained("random");
        end
    endtask

    initial begin
        rst            = 1'b0;
        data_in        = '0;
        data_in_valid  = '0;
        data_out_ready = 1'b0;
        test_reset();
        test_stream();
        test_head_delay();
        test_ready_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_gqa_head_gather

// File: doc/gqa_head_gather.md
# gqa_head_gather

Reassembles per-head attention outputs into one streaming tensor, in the original row-major packet order. Sits downstream of the grouped-query-attention head scatter stage and its per-head attention cores. It accepts NUM_HEADS independent valid/ready streams and emits a single stream for the output projection. Packets are interleaved so that head h's columns land at dim-0 offset h × HEAD_SIZE.

## Interface
Parameters:
- NUM_HEADS, 12: number of head streams gathered.
- IN_DATA_TENSOR_SIZE_DIM_0, 768: full tensor width (all heads concatenated).
- IN_DATA_TENSOR_SIZE_DIM_1, 32: tensor rows.
- IN_DATA_PARALLELISM_DIM_0, 4: elements per packet along dim 0.
- IN_DATA_PARALLELISM_DIM_1, 4: elements per packet along dim 1.
- IN_DATA_PRECISION_0, 16: element width in bits.

Ports (P = PARALLELISM_DIM_0 × PARALLELISM_DIM_1):
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- data_in  in  NUM_HEADS×P×PRECISION  per-head packets.
- data_in_valid  in  NUM_HEADS  per-head valid.
- data_in_ready  out  NUM_HEADS  per-head ready.
- data_out  out  P×PRECISION  gathered packet.
- data_out_valid  out  1  output valid.
- data_out_ready  in  1  output ready.
- data_out_last  out  1  high with the final packet of each tensor.

## Operation
Derived constants:
- HEAD_SIZE = DIM_0 / NUM_HEADS.
- DEPTH_0 = HEAD_SIZE / PAR_0.
- DEPTH_1 = DIM_1 / PAR_1.
- Divisibility of all three is checked by elaboration-time asserts.

Counters:
- blk_ctr, range 0..DEPTH_0-1.
- head_ctr, range 0..NUM_HEADS-1.
- row_ctr, range 0..DEPTH_1-1.
- Each counter is $clog2 wide, minimum 1 bit.

Packet order per tensor: for each row_ctr, for each head_ctr, for each blk_ctr.

Handshake and routing:
- Only head_ctr is selected.
- data_in_ready[head_ctr] = downstream-ready; all other data_in_ready bits are 0.
- Unselected data_in_valid and data_in are ignored; heads running ahead are stalled by their own upstream FIFOs.

Counters advance on a selected-input handshake (data_in_valid[head_ctr] && data_in_ready[head_ctr]):
- blk_ctr increments.
- When blk_ctr wraps, head_ctr increments.
- When head_ctr wraps, row_ctr increments.
- When row_ctr wraps at its last value, all counters return to 0 and the next tensor starts with no idle cycle.

data_out_last is high on the packet where all three counters are at their maximum.

Reset:
- Asserting rst mid-tensor clears all counters and any held output packet immediately.
- Partial tensors are discarded; upstream must also be reset.

## Timing
Reset values:
- data_out_valid = 0, data_out_last = 0, data_out = 0.
- data_in_ready = 0 while rst is low.

Without the output register:
- Zero latency: data_out_valid = data_in_valid[head_ctr] and data_out = data_in[head_ctr], both combinational.
- data_out_last is combinational from the counters.
- Throughput is one packet per cycle.

data_out_ready low:
- The selected input stalls and the counters hold.
- data_out must stay stable while valid && !ready.

Single head (NUM_HEADS = 1): pure pass-through plus last generation.

## Configuration
GQA_GATHER_OUT_REG_EN:
- Defined: a two-entry skid buffer sits between the mux and data_out. Latency is 1 cycle at full throughput; data_in_ready derives from the buffer's registered ready, so there is no combinational ready path from data_out_ready to data_in_ready. data_out_last travels with its packet.
- Undefined: the combinational path described above.

## Structure
- Shared package gqa_pkg: derived-constant functions (head size, depths, counter width) and a packed counter-state typedef, shared with the scatter control stage.
- Natural sub-module: gqa_gather_skid_buffer (two-entry skid buffer, DATA_WIDTH parameter), instantiated only under GQA_GATHER_OUT_REG_EN.
- Counters and mux live in the top module.

## Test plan
The bench config is NUM_HEADS=4, DIM_0=16, DIM_1=4, PAR_0=2, PAR_1=2, so DEPTH_0=2, DEPTH_1=2 and there are 16 packets per tensor.

- All heads always valid, data = {head, row, blk}, ready=1 -> output order h0b0,h0b1,h1b0,…,h3b1 for row 0, then the same for row 1. 16 packets in 16 cycles; last on packet 16 only.
- Head 2 valid delayed 10 cycles, others always valid -> output stalls after h1b1, resumes with h2b0. data_in_ready[3] stays 0 until h2b1 is accepted.
- data_out_ready toggled 1010… -> every packet is delivered exactly once, data is stable during stalls, 16 packets in 32 cycles.
- Two back-to-back tensors -> packet 17 is row0 h0b0 in the cycle after last; no bubble.
- rst asserted after 5 packets, then released -> valid=0 and ready=0 during reset; the first packet after release is h0b0, row 0.
- With GQA_GATHER_OUT_REG_EN, first scenario -> first output 1 cycle after the first input, same order, one packet per cycle sustained, ready fully registered.
